// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the debounce bank
// Purpose: per-channel event struct and the default-threshold helper.
// Ports: none (package).
package debounce_pkg;

  // One-cycle edge events produced by a single channel.
  typedef struct packed {
    logic rise;
    logic fall;
  } debounce_evt_t;

  // Saturation value of a WIDTH-bit counter; also the default high threshold.
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one saturating integrator with hysteresis and edge pulses
// Purpose: integrates one raw input, switches the output at HI/LO thresholds
//          and emits one-clk rise/fall pulses on output changes.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   clk_enable       - advance strobe; counter and output hold when low
//   data             - raw input bit
//   debounced        - conditioned output bit
//   evt              - {rise, fall} one-clk event pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HI_THRESH = cnt_max(WIDTH),
  parameter int LO_THRESH = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          data,
  output logic          debounced,
  output debounce_evt_t evt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] HI_T    = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO_T    = WIDTH'(LO_THRESH);

  logic [WIDTH-1:0] total;

  always_ff @(posedge clk) begin
    if (reset) begin
      total     <= '0;
      debounced <= 1'b0;
      evt       <= '0;
    end else begin
      // Pulses last one clk whether or not the next edge is enabled.
      evt <= '0;
      if (clk_enable) begin
        if (data && (total != CNT_MAX)) begin
          total <= total + 1'b1;
        end else if (!data && (total != '0)) begin
          total <= total - 1'b1;
        end
        // Threshold decision deliberately uses the pre-update count.
        if (total >= HI_T) begin
          debounced <= 1'b1;
          evt.rise  <= !debounced;
        end else if (total <= LO_T) begin
          debounced <= 1'b0;
          evt.fall  <= debounced;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with edge events and sticky flags
// Purpose: CHANNELS independent debounce channels; optional sticky event flags
//          and irq built only when DEBOUNCE_BANK_EVENT_LATCH_EN is defined.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   clk_enable              - sample/advance strobe
//   data[CHANNELS]          - raw inputs (already synchronised)
//   debounced[CHANNELS]     - conditioned outputs
//   rise/fall[CHANNELS]     - one-clk edge pulses
//   event_clear[CHANNELS]   - write-1-to-clear of both sticky flags per channel
//   rise_seen/fall_seen     - sticky edge flags (0 when the macro is undefined)
//   irq                     - OR of all sticky flags (0 when the macro is undefined)
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int WIDTH     = 8,
  parameter int HI_THRESH = cnt_max(WIDTH),
  parameter int LO_THRESH = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [CHANNELS-1:0] data,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  input  logic [CHANNELS-1:0] event_clear,
  output logic [CHANNELS-1:0] rise_seen,
  output logic [CHANNELS-1:0] fall_seen,
  output logic                irq
);

  if (!((LO_THRESH < HI_THRESH) && (HI_THRESH <= cnt_max(WIDTH)))) begin : g_bad_thresh
    $error("debounce_bank: thresholds must satisfy LO_THRESH < HI_THRESH <= 2**WIDTH-1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_evt_t evt;

    debounce_channel #(
      .WIDTH    (WIDTH),
      .HI_THRESH(HI_THRESH),
      .LO_THRESH(LO_THRESH)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .clk_enable(clk_enable),
      .data      (data[i]),
      .debounced (debounced[i]),
      .evt       (evt)
    );

    assign rise[i] = evt.rise;
    assign fall[i] = evt.fall;
  end

`ifdef DEBOUNCE_BANK_EVENT_LATCH_EN
  logic [CHANNELS-1:0] rise_flags;
  logic [CHANNELS-1:0] fall_flags;

  // Set has priority over clear so an event landing with a clear is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_flags <= '0;
      fall_flags <= '0;
    end else begin
      rise_flags <= (rise_flags & ~event_clear) | rise;
      fall_flags <= (fall_flags & ~event_clear) | fall;
    end
  end

  assign rise_seen = rise_flags;
  assign fall_seen = fall_flags;
  assign irq       = |{rise_flags, fall_flags};
`else
  logic unused_event_clear;
  assign unused_event_clear = ^event_clear;
  assign rise_seen = '0;
  assign fall_seen = '0;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank
module tb_debounce_bank;

  localparam int CH   = 8;
  localparam int W    = 4;
  localparam int HI   = 12;
  localparam int LO   = 3;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic [CH-1:0] data;
  logic [CH-1:0] event_clear;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] rise_seen;
  logic [CH-1:0] fall_seen;
  logic          irq;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model state
  int m_total[CH];
  bit m_deb[CH];
  bit m_rise[CH];
  bit m_fall[CH];
  bit m_rs[CH];
  bit m_fs[CH];

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .HI_THRESH(HI),
    .LO_THRESH(LO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .data       (data),
    .debounced  (debounced),
    .rise       (rise),
    .fall       (fall),
    .event_clear(event_clear),
    .rise_seen  (rise_seen),
    .fall_seen  (fall_seen),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input logic [CH-1:0] d,
                            input logic [CH-1:0] clr);
    bit was;
    for (int i = 0; i < CH; i++) begin
      if (r) begin
        m_total[i] = 0; m_deb[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        m_rs[i] = 0; m_fs[i] = 0;
      end else begin
`ifdef DEBOUNCE_BANK_EVENT_LATCH_EN
        m_rs[i] = (m_rs[i] && !clr[i]) || m_rise[i];
        m_fs[i] = (m_fs[i] && !clr[i]) || m_fall[i];
`endif
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (en) begin
          was = m_deb[i];
          if (m_total[i] >= HI) m_deb[i] = 1;
          else if (m_total[i] <= LO) m_deb[i] = 0;
          m_rise[i] = m_deb[i] && !was;
          m_fall[i] = !m_deb[i] && was;
          if (d[i]) m_total[i] = (m_total[i] + 1 > CMAX) ? CMAX : m_total[i] + 1;
          else      m_total[i] = (m_total[i] - 1 < 0) ? 0 : m_total[i] - 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_deb, e_rise, e_fall, e_rs, e_fs;
    for (int i = 0; i < CH; i++) begin
      e_deb[i] = m_deb[i]; e_rise[i] = m_rise[i]; e_fall[i] = m_fall[i];
      e_rs[i] = m_rs[i]; e_fs[i] = m_fs[i];
    end
    check("debounced", 32'(debounced), 32'(e_deb));
    check("rise", 32'(rise), 32'(e_rise));
    check("fall", 32'(fall), 32'(e_fall));
    check("rise_seen", 32'(rise_seen), 32'(e_rs));
    check("fall_seen", 32'(fall_seen), 32'(e_fs));
    check("irq", 32'(irq), 32'((|e_rs) | (|e_fs)));
  endtask

  task automatic tick(input bit r, input bit en, input logic [CH-1:0] d,
                      input logic [CH-1:0] clr);
    reset = r; clk_enable = en; data = d; event_clear = clr;
    @(posedge clk);
    model_step(r, en, d, clr);
    #1;
    compare_all();
  endtask

  initial begin
    int lat, pulses, ev, strobes, strobe_at, n;
    logic [CH-1:0] rnd_data, rnd_clr;
    reset = 1'b1; clk_enable = 1'b1; data = '1; event_clear = '0;

    // Reset with data all ones, then first edge after release
    for (int k = 0; k < 3; k++) tick(1, 1, '1, '0);
    check("rst_outputs", 32'({debounced, rise, fall, rise_seen, fall_seen} != 0), 0);
    tick(0, 1, '1, '0);
    check("post_rst_deb", 32'(debounced), 0);

    // Rise latency and saturation on channel 0
    tick(1, 1, '0, '0);
    lat = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(0, 1, 8'h01, '0);
      if (rise[0]) pulses++;
      if (debounced[0] && lat == 0) lat = k;
    end
    check("rise_lat", lat, 13);
    check("rise_width", pulses, 1);
    check("others_quiet", 32'(debounced[CH-1:1]), 0);

    // Fall latency from saturation
    lat = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(0, 1, 8'h00, '0);
      if (fall[0]) pulses++;
      if (!debounced[0] && lat == 0) lat = k;
    end
    check("fall_lat", lat, 13);
    check("fall_width", pulses, 1);

    // Glitch rejection, then a clean rise from zero again
    tick(1, 1, '0, '0);
    ev = 0;
    for (int k = 0; k < 5; k++) begin tick(0, 1, 8'h01, '0); if (debounced[0]) ev++; end
    for (int k = 0; k < 10; k++) begin tick(0, 1, 8'h00, '0); if (debounced[0]) ev++; end
    check("glitch_deb", ev, 0);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      tick(0, 1, 8'h01, '0);
      if (debounced[0] && lat == 0) lat = k;
    end
    check("glitch_relat", lat, 13);

    // Hysteresis: bounce between counts 4 and 11 with output held high
    tick(1, 1, '0, '0);
    for (int k = 0; k < 20; k++) tick(0, 1, 8'h01, '0);
    for (int k = 0; k < 11; k++) tick(0, 1, 8'h00, '0);
    ev = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 7; k++) begin tick(0, 1, 8'h01, '0); if (rise[0] || fall[0]) ev++; end
      for (int k = 0; k < 7; k++) begin tick(0, 1, 8'h00, '0); if (rise[0] || fall[0]) ev++; end
    end
    check("bounce_events", ev, 0);
    check("bounce_hold", 32'(debounced[0]), 1);

    // Enable every 4th clk
    tick(1, 1, '0, '0);
    lat = 0; pulses = 0; strobes = 0; strobe_at = 0;
    for (int c = 1; c <= 80; c++) begin
      tick(0, (c % 4) == 0, 8'h01, '0);
      if ((c % 4) == 0) strobes++;
      if (rise[0]) pulses++;
      if (debounced[0] && lat == 0) begin lat = c; strobe_at = strobes; end
    end
    check("en_rise_clk", lat, 52);
    check("en_rise_strobe", strobe_at, 13);
    check("en_rise_width", pulses, 1);

`ifdef DEBOUNCE_BANK_EVENT_LATCH_EN
    // Sticky flags on channel 2
    tick(1, 1, '0, '0);
    for (int k = 0; k < 14; k++) tick(0, 1, 8'h04, '0);
    check("rs2_set", 32'(rise_seen[2]), 1);
    check("irq_set", 32'(irq), 1);
    n = 0;
    while (!fall[2] && n < 40) begin tick(0, 1, 8'h00, '0); n++; end
    check("fall2_found", 32'(fall[2]), 1);
    n = 0;
    while (!rise[2] && n < 40) begin tick(0, 1, 8'h04, '0); n++; end
    check("rise2_found", 32'(rise[2]), 1);
    tick(0, 1, 8'h04, 8'h04);
    check("clr_vs_set", 32'(rise_seen[2]), 1);
    tick(0, 1, 8'h04, 8'h04);
    check("clr_rs2", 32'(rise_seen[2]), 0);
    check("clr_fs2", 32'(fall_seen[2]), 0);
    check("clr_irq", 32'(irq), 0);
    n = 0;
    while (!fall[2] && n < 40) begin tick(0, 1, 8'h00, '0); n++; end
    tick(0, 1, 8'h04, '0);
    check("fs2_set", 32'(fall_seen[2]), 1);
    for (int k = 0; k < 4; k++) tick(0, 1, 8'h04, '0);
    tick(1, 1, 8'h04, '0);
    check("rst_flags", 32'({rise_seen, fall_seen}), 0);
    check("rst_irq", 32'(irq), 0);
`endif

    // Randomized traffic on all channels
    rnd_data = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(15) == 0) rnd_data[i] = ~rnd_data[i];
        rnd_clr[i] = ($urandom_range(7) == 0);
      end
      tick($urandom_range(499) == 0, $urandom_range(3) != 0, rnd_data, rnd_clr);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
